mul_sequencer: RTL and testbench

//  Control sequencer for the shift-add unsigned multiplier. Accepts a MULTU request from
//  the decode/ALU-control stage, clears the multiplier, drives Signal/counter through

---
 rtl/mul_sequencer_if.sv | 31 +++
 rtl/mul_sequencer.sv | 110 +++++++++++
 tb/tb_mul_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_sequencer_if.sv
// Request/command bundle between decode/ALU-control, the multiply sequencer and the
// shift-add multiplier datapath.
interface mul_sequencer_if #(
  parameter int unsigned CNT_W = 6
) ();

  logic             start;
  logic [5:0]       op;
  logic             flush;
  logic             rd_hilo;
  logic [5:0]       mul_signal;
  logic [CNT_W-1:0] mul_counter;
  logic             mul_clear;
  logic             busy;
  logic             done;
  logic             hilo_we;
  logic             stall;

  // Requester side: decode stage issuing MULTU / MFHI / MFLO
  modport master (
    output start, op, flush, rd_hilo,
    input  mul_signal, mul_counter, mul_clear, busy, done, hilo_we, stall
  );

  // Sequencer side
  modport slave (
    input  start, op, flush, rd_hilo,
    output mul_signal, mul_counter, mul_clear, busy, done, hilo_we, stall
  );

endinterface

// File: rtl/mul_sequencer.sv
// Control sequencer for the shift-add unsigned multiplier: clear, WIDTH accumulate
// iterations, product latch, then a one-cycle HI/LO commit.
module mul_sequencer #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CNT_W      = 6,
  parameter logic [5:0]  MULTU_CODE = 6'b011001,
  parameter logic [5:0]  OUT_CODE   = 6'b111111,
  parameter logic [5:0]  IDLE_CODE  = 6'b000000
) (
  input  logic           clk,
  input  logic           reset,
  mul_sequencer_if.slave bus
);

  localparam int unsigned      OP_W     = 6;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [OP_W-1:0]  r_sig;
  logic [OP_W-1:0]  w_sig;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt;
  logic             r_clear;
  logic             w_clear;
  logic             r_busy;
  logic             w_busy;
  logic             r_done;
  logic             w_done;
  logic             w_accept;

  assign w_accept = bus.start && (bus.op == MULTU_CODE);

  // Next state and the output values that go with it, so every output is a flop
  always_comb begin
    w_next  = r_state;
    w_sig   = IDLE_CODE;
    w_cnt   = '0;
    w_clear = 1'b0;
    w_busy  = 1'b1;
    w_done  = 1'b0;

    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_CLEAR;
      S_CLEAR: w_next = bus.flush ? S_IDLE : S_RUN;
      S_RUN: begin
        if (bus.flush)               w_next = S_IDLE;
        else if (r_cnt == LAST_CNT)  w_next = S_OUT;
      end
      S_OUT:   w_next = bus.flush ? S_IDLE : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase

    case (w_next)
      S_IDLE:  w_busy = 1'b0;
      S_CLEAR: w_clear = 1'b1;
      S_RUN: begin
        w_sig = MULTU_CODE;
        w_cnt = (r_state == S_RUN) ? r_cnt + CNT_W'(1) : '0;
      end
      S_OUT: begin
        w_sig = OUT_CODE;
        w_cnt = r_cnt;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_cnt  = r_cnt;
      end
      default: w_busy = 1'b0;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_sig   <= IDLE_CODE;
      r_cnt   <= '0;
      r_clear <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sig   <= w_sig;
      r_cnt   <= w_cnt;
      r_clear <= w_clear;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign bus.mul_signal  = r_sig;
  assign bus.mul_counter = r_cnt;
  assign bus.mul_clear   = r_clear;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.hilo_we     = r_done;
  // MFHI/MFLO must wait for the in-flight product, including the commit cycle
  assign bus.stall       = bus.rd_hilo & r_busy;

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: directed scenarios plus random traffic against a
// cycle-count reference model and a behavioural shift-add multiplier.
module tb_mul_sequencer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 6;
  localparam logic [5:0]  MULTU = 6'b011001;
  localparam logic [5:0]  OUTC  = 6'b111111;
  localparam logic [5:0]  IDLEC = 6'b000000;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mul_sequencer_if #(.CNT_W(CNT_W)) ifc ();

  mul_sequencer #(
    .WIDTH(WIDTH), .CNT_W(CNT_W),
    .MULTU_CODE(MULTU), .OUT_CODE(OUTC), .IDLE_CODE(IDLEC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a multiply is "t cycles since acceptance"; t=0 clear, 1..WIDTH run,
  // WIDTH+1 out, WIDTH+2 done.
  logic        m_act = 1'b0;
  int unsigned m_t   = 0;
  logic [31:0] nxt_a = '0, nxt_b = '0, cur_a = '0, cur_b = '0;
  logic [63:0] acc = '0, prod = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_act <= 1'b0;
    end else if (!m_act) begin
      if (ifc.start && ifc.op == MULTU) begin
        m_act <= 1'b1;
        m_t   <= 0;
        cur_a <= nxt_a;
        cur_b <= nxt_b;
      end
    end else if (ifc.flush && m_t <= WIDTH + 1) begin
      m_act <= 1'b0;
    end else if (m_t == WIDTH + 2) begin
      m_act <= 1'b0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  // Behavioural multiplier datapath driven by the sequencer's commands
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ifc.mul_clear)
      acc <= '0;
    else if (ifc.mul_signal == MULTU && cur_b[ifc.mul_counter[4:0]])
      acc <= acc + (64'(cur_a) << ifc.mul_counter);
    if (ifc.mul_signal == OUTC)
      prod <= acc;
  end

  function automatic logic [5:0] f_sig(input logic act, input int unsigned t);
    if (!act || t == 0 || t == WIDTH + 2) return IDLEC;
    if (t <= WIDTH) return MULTU;
    return OUTC;
  endfunction

  function automatic logic [5:0] f_cnt(input int unsigned t);
    if (t >= 1 && t <= WIDTH) return 6'(t - 1);
    if (t == WIDTH + 1) return 6'(WIDTH - 1);
    return 6'd0;
  endfunction

  // Every-cycle comparison against the reference
  always @(negedge clk) begin
    chk("m_busy",    64'(ifc.busy),       64'(m_act));
    chk("m_clear",   64'(ifc.mul_clear),  64'(m_act && m_t == 0));
    chk("m_signal",  64'(ifc.mul_signal), 64'(f_sig(m_act, m_t)));
    chk("m_done",    64'(ifc.done),       64'(m_act && m_t == WIDTH + 2));
    chk("m_hilo_we", 64'(ifc.hilo_we),    64'(m_act && m_t == WIDTH + 2));
    chk("m_stall",   64'(ifc.stall),      64'(ifc.rd_hilo & m_act));
    if (m_act && m_t <= WIDTH + 1)
      chk("m_counter", 64'(ifc.mul_counter), 64'(f_cnt(m_t)));
    if (m_act && m_t == WIDTH + 2)
      chk("m_product", prod, 64'(cur_a) * 64'(cur_b));
  end

  task automatic wait_done(output int c);
    logic ok;
    ok = 1'b0;
    c  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ifc.done) begin
        ok = 1'b1;
        c  = cyc;
        break;
      end
    end
    chk("done_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_count(input logic [5:0] n);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ifc.mul_signal == MULTU && ifc.mul_counter == n) begin
        ok = 1'b1;
        break;
      end
    end
    chk("count_timeout", 64'(ok), 64'd1);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2;
    nxt_a     = a;
    nxt_b     = b;
    ifc.start = 1'b1;
    ifc.op    = MULTU;
    @(posedge clk); #2;
    ifc.start = 1'b0;
  endtask

  initial begin
    int c1, c2;
    logic ok;
    ifc.start = 1'b0; ifc.op = '0; ifc.flush = 1'b0; ifc.rd_hilo = 1'b0;
    #1 reset = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_signal",  64'(ifc.mul_signal),  64'(IDLEC));
    chk("rst_counter", 64'(ifc.mul_counter), 64'd0);
    chk("rst_clear",   64'(ifc.mul_clear),   64'd0);
    chk("rst_busy",    64'(ifc.busy),        64'd0);
    chk("rst_done",    64'(ifc.done),        64'd0);
    chk("rst_hilo_we", 64'(ifc.hilo_we),     64'd0);
    @(posedge clk); #2 reset = 1'b1;

    // Full-width multiply, timing pinned edge by edge
    @(posedge clk); #2;
    nxt_a = 32'hFFFF_FFFF; nxt_b = 32'hFFFF_FFFF;
    ifc.start = 1'b1; ifc.op = MULTU;
    @(posedge clk); #2 ifc.start = 1'b0;
    @(negedge clk);
    chk("t1_clear", 64'(ifc.mul_clear), 64'd1);
    chk("t1_busy",  64'(ifc.busy),      64'd1);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("t1_run_sig", 64'(ifc.mul_signal),  64'(MULTU));
      chk("t1_run_cnt", 64'(ifc.mul_counter), 64'(i));
    end
    @(negedge clk);
    chk("t1_out_sig", 64'(ifc.mul_signal),  64'(OUTC));
    chk("t1_out_cnt", 64'(ifc.mul_counter), 64'd31);
    @(negedge clk);
    chk("t2_done",    64'(ifc.done),    64'd1);
    chk("t2_hilo_we", 64'(ifc.hilo_we), 64'd1);
    chk("t2_product", prod, 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);
    chk("t2_done_pulse", 64'(ifc.done), 64'd0);
    chk("t2_idle_busy",  64'(ifc.busy), 64'd0);

    // Back-to-back with start held high
    @(posedge clk); #2;
    nxt_a = 32'd7; nxt_b = 32'd9;
    ifc.start = 1'b1; ifc.op = MULTU;
    wait_done(c1);
    chk("t3_first_prod", prod, 64'd63);
    ok = 1'b0; c2 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ifc.mul_clear) begin ok = 1'b1; c2 = cyc; break; end
    end
    chk("t3_clear_seen", 64'(ok), 64'd1);
    chk("t3_gap", 64'(c2 - c1), 64'd2);
    @(posedge clk); #2 ifc.start = 1'b0;
    wait_done(c1);
    chk("t3_second_prod", prod, 64'd63);

    // Non-MULTU op is ignored
    @(posedge clk); #2;
    ifc.start = 1'b1; ifc.op = 6'b011000;
    repeat (3) begin
      @(negedge clk);
      chk("t4_busy",  64'(ifc.busy),      64'd0);
      chk("t4_clear", 64'(ifc.mul_clear), 64'd0);
    end
    @(posedge clk); #2 ifc.start = 1'b0;

    // Flush at counter 10, then a clean 3*5
    issue($urandom, $urandom);
    wait_count(6'd10);
    #1 ifc.flush = 1'b1;
    @(posedge clk); #2 ifc.flush = 1'b0;
    @(negedge clk);
    chk("t5_busy",   64'(ifc.busy),        64'd0);
    chk("t5_signal", 64'(ifc.mul_signal),  64'(IDLEC));
    chk("t5_cnt",    64'(ifc.mul_counter), 64'd0);
    repeat (40) begin
      @(negedge clk);
      chk("t5_no_done", 64'({ifc.done, ifc.hilo_we}), 64'd0);
    end
    issue(32'd3, 32'd5);
    wait_done(c1);
    chk("t5_product", prod, 64'd15);

    // Stall during RUN, async reset at counter 20, stall through DONE
    ifc.rd_hilo = 1'b1;
    issue($urandom, $urandom);
    wait_count(6'd0);
    chk("t6_stall_run", 64'(ifc.stall), 64'd1);
    wait_count(6'd20);
    #1 reset = 1'b0;
    #1;
    chk("t6_rst_sig",   64'(ifc.mul_signal),  64'(IDLEC));
    chk("t6_rst_cnt",   64'(ifc.mul_counter), 64'd0);
    chk("t6_rst_busy",  64'(ifc.busy),        64'd0);
    chk("t6_rst_stall", 64'(ifc.stall),       64'd0);
    @(posedge clk); #2 reset = 1'b1;
    issue(32'd12, 32'd11);
    wait_done(c1);
    chk("t6_stall_done", 64'(ifc.stall), 64'd1);
    chk("t6_product",    prod,           64'd132);
    @(negedge clk);
    chk("t6_stall_idle", 64'(ifc.stall), 64'd0);
    @(posedge clk); #2 ifc.rd_hilo = 1'b0;

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      nxt_a       = $urandom;
      nxt_b       = $urandom;
      ifc.start   = ($urandom_range(0, 3) == 0);
      ifc.op      = ($urandom_range(0, 3) != 0) ? MULTU : 6'($urandom);
      ifc.flush   = ($urandom_range(0, 39) == 0);
      ifc.rd_hilo = 1'($urandom_range(0, 1));
      reset       = ($urandom_range(0, 599) != 0);
    end
    @(posedge clk); #2;
    reset = 1'b1; ifc.start = 1'b0; ifc.flush = 1'b0; ifc.rd_hilo = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
